// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - ID-stage register scoreboard: load-use stall, drain (Idle) and sticky Err.
// Optional HAZARD_PERF_EN adds StallCycles / LoadUseStalls performance counters.
module hazard_scoreboard #(
    parameter int NUM_REGS = 32,
    parameter int OUT_W    = 3,
    parameter int LOAD_LAT = 1,
    parameter int ALU_LAT  = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] ID_Rs1,
    input  logic [4:0] ID_Rs2,
    input  logic       ID_UseRs1,
    input  logic       ID_UseRs2,
    input  logic       ID_Issue,
    input  logic [4:0] ID_Rd,
    input  logic       ID_RegWrite,
    input  logic       ID_MemRead,
    input  logic       Flush,
    input  logic [4:0] Flush_Rd,
    input  logic       Flush_RegWrite,
    input  logic [4:0] WB_Rd,
    input  logic       WB_RegWrite,
    output logic       Stall,
    output logic       Idle,
    output logic       Err
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0] StallCycles,
    output logic [31:0] LoadUseStalls
`endif
);
    localparam logic [1:0] LOAD_CNT = LOAD_LAT[1:0];
    localparam logic [1:0] ALU_CNT  = ALU_LAT[1:0];

    logic                w_issue;
    logic                w_retire;
    logic                w_flush;
    logic                w_src1_stall;
    logic                w_src2_stall;
    logic [NUM_REGS-1:0] w_cnt_nz;
    logic [NUM_REGS-1:0] w_out_nz;
    logic [NUM_REGS-1:0] w_ovf;
    logic [NUM_REGS-1:0] w_unf;
    logic                r_err;
`ifdef HAZARD_PERF_EN
    logic [NUM_REGS-1:0] w_is_load;
    logic                r_stall_q;
    logic [31:0]         r_stall_cycles;
    logic [31:0]         r_load_use;
`endif

    assign w_issue  = ID_Issue & ID_RegWrite & (ID_Rd != 5'd0);
    assign w_retire = WB_RegWrite & (WB_Rd != 5'd0);
    assign w_flush  = Flush & Flush_RegWrite & (Flush_Rd != 5'd0);

    // x0 is hardwired: never outstanding, never stalls.
    assign w_cnt_nz[0] = 1'b0;
    assign w_out_nz[0] = 1'b0;
    assign w_ovf[0]    = 1'b0;
    assign w_unf[0]    = 1'b0;
`ifdef HAZARD_PERF_EN
    assign w_is_load[0] = 1'b0;
`endif

    for (genvar g = 1; g < NUM_REGS; g++) begin : g_reg
        logic             w_inc;
        logic             w_ret;
        logic             w_fl;
        logic [OUT_W+1:0] w_sum;
        logic [OUT_W-1:0] r_out;
        logic [1:0]       r_cnt;

        assign w_inc = w_issue  && (ID_Rd    == 5'(g));
        assign w_ret = w_retire && (WB_Rd    == 5'(g));
        assign w_fl  = w_flush  && (Flush_Rd == 5'(g));

        // Two guard bits: MSB flags a negative result, the next one a result above max.
        assign w_sum = {2'b00, r_out} + {{(OUT_W+1){1'b0}}, w_inc}
                     - {{(OUT_W+1){1'b0}}, w_ret} - {{(OUT_W+1){1'b0}}, w_fl};
        assign w_unf[g]    = w_sum[OUT_W+1];
        assign w_ovf[g]    = ~w_sum[OUT_W+1] & w_sum[OUT_W];
        assign w_cnt_nz[g] = (r_cnt != 2'd0);
        assign w_out_nz[g] = (r_out != '0);

        always_ff @(posedge clk) begin
            if (rst) begin
                r_out <= '0;
                r_cnt <= 2'd0;
            end else begin
                if (w_unf[g])
                    r_out <= '0;
                else if (w_ovf[g])
                    r_out <= '1;
                else
                    r_out <= w_sum[OUT_W-1:0];

                if (w_inc)
                    r_cnt <= ID_MemRead ? LOAD_CNT : ALU_CNT;
                else if (w_fl)
                    r_cnt <= 2'd0;
                else if (r_cnt != 2'd0)
                    r_cnt <= r_cnt - 2'd1;
            end
        end

`ifdef HAZARD_PERF_EN
        logic r_is_load;
        always_ff @(posedge clk) begin
            if (rst)
                r_is_load <= 1'b0;
            else if (w_inc)
                r_is_load <= ID_MemRead;
        end
        assign w_is_load[g] = r_is_load;
`endif
    end

    assign w_src1_stall = ID_UseRs1 & (ID_Rs1 != 5'd0) & w_cnt_nz[ID_Rs1];
    assign w_src2_stall = ID_UseRs2 & (ID_Rs2 != 5'd0) & w_cnt_nz[ID_Rs2];
    assign Stall        = w_src1_stall | w_src2_stall;
    assign Idle         = ~|w_out_nz;
    assign Err          = r_err;

    always_ff @(posedge clk) begin
        if (rst)
            r_err <= 1'b0;
        else if ((|w_ovf) || (|w_unf))
            r_err <= 1'b1;
    end

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_q      <= 1'b0;
            r_stall_cycles <= 32'd0;
            r_load_use     <= 32'd0;
        end else begin
            r_stall_q <= Stall;
            if (Stall)
                r_stall_cycles <= r_stall_cycles + 32'd1;
            if (Stall && !r_stall_q &&
                ((w_src1_stall && w_is_load[ID_Rs1]) || (w_src2_stall && w_is_load[ID_Rs2])))
                r_load_use <= r_load_use + 32'd1;
        end
    end
    assign StallCycles   = r_stall_cycles;
    assign LoadUseStalls = r_load_use;
`endif
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - directed and randomized checks of hazard_scoreboard against a reference model.
module tb_hazard_scoreboard;
    localparam int LOAD_LAT = 1;
    localparam int ALU_LAT  = 0;
    localparam int OUT_MAX  = 7;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] ID_Rs1, ID_Rs2, ID_Rd, Flush_Rd, WB_Rd;
    logic       ID_UseRs1, ID_UseRs2, ID_Issue, ID_RegWrite, ID_MemRead;
    logic       Flush, Flush_RegWrite, WB_RegWrite;
    logic       Stall, Idle, Err;
`ifdef HAZARD_PERF_EN
    logic [31:0] StallCycles, LoadUseStalls;
`endif

    hazard_scoreboard dut (
        .clk(clk), .rst(rst),
        .ID_Rs1(ID_Rs1), .ID_Rs2(ID_Rs2), .ID_UseRs1(ID_UseRs1), .ID_UseRs2(ID_UseRs2),
        .ID_Issue(ID_Issue), .ID_Rd(ID_Rd), .ID_RegWrite(ID_RegWrite), .ID_MemRead(ID_MemRead),
        .Flush(Flush), .Flush_Rd(Flush_Rd), .Flush_RegWrite(Flush_RegWrite),
        .WB_Rd(WB_Rd), .WB_RegWrite(WB_RegWrite),
        .Stall(Stall), .Idle(Idle), .Err(Err)
`ifdef HAZARD_PERF_EN
        , .StallCycles(StallCycles), .LoadUseStalls(LoadUseStalls)
`endif
    );

    always #5 clk = ~clk;

    // Reference: writers in flight per register, and the first cycle its value is forwardable.
    int     m_out[32];
    longint m_ready[32];
    bit     m_err;
    longint cyc;
    int     n_checks;
    int     n_errors;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h cycle=%0d", tag, got, exp, cyc);
        end
    endtask

    function automatic bit exp_stall();
        bit s1, s2;
        s1 = ID_UseRs1 && ID_Rs1 != 0 && cyc < m_ready[ID_Rs1];
        s2 = ID_UseRs2 && ID_Rs2 != 0 && cyc < m_ready[ID_Rs2];
        return s1 || s2;
    endfunction

    function automatic bit exp_idle();
        for (int r = 1; r < 32; r++)
            if (m_out[r] != 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic void model_edge();
        int n;
        if (rst) begin
            for (int r = 0; r < 32; r++) begin
                m_out[r]   = 0;
                m_ready[r] = 0;
            end
            m_err = 1'b0;
            return;
        end
        for (int r = 1; r < 32; r++) begin
            bit inc, ret, fl;
            inc = ID_Issue && ID_RegWrite && ID_Rd == r;
            ret = WB_RegWrite && WB_Rd == r;
            fl  = Flush && Flush_RegWrite && Flush_Rd == r;
            n = m_out[r] + int'(inc) - int'(ret) - int'(fl);
            if (n > OUT_MAX) begin n = OUT_MAX; m_err = 1'b1; end
            if (n < 0)       begin n = 0;       m_err = 1'b1; end
            m_out[r] = n;
            if (inc)
                m_ready[r] = cyc + 1 + (ID_MemRead ? LOAD_LAT : ALU_LAT);
            else if (fl)
                m_ready[r] = cyc + 1;
        end
    endfunction

    task automatic clear_in();
        rst = 1'b0;
        ID_Rs1 = 0; ID_Rs2 = 0; ID_UseRs1 = 0; ID_UseRs2 = 0;
        ID_Issue = 0; ID_Rd = 0; ID_RegWrite = 0; ID_MemRead = 0;
        Flush = 0; Flush_Rd = 0; Flush_RegWrite = 0;
        WB_Rd = 0; WB_RegWrite = 0;
    endtask

    task automatic tick();
        @(negedge clk);
        check("stall", {31'd0, Stall}, {31'd0, exp_stall()});
        check("idle",  {31'd0, Idle},  {31'd0, exp_idle()});
        check("err",   {31'd0, Err},   {31'd0, m_err});
        @(posedge clk);
        model_edge();
        cyc++;
        #1;
    endtask

    task automatic issue(input logic [4:0] rd, input logic ld);
        ID_Issue = 1; ID_RegWrite = 1; ID_Rd = rd; ID_MemRead = ld;
    endtask

    task automatic retire(input logic [4:0] rd);
        WB_RegWrite = 1; WB_Rd = rd;
    endtask

    initial begin
        n_checks = 0; n_errors = 0; cyc = 0; m_err = 0;
        for (int r = 0; r < 32; r++) begin m_out[r] = 0; m_ready[r] = 0; end
        clear_in();
        rst = 1; tick(); tick(); clear_in();
        #1;
        check("rst_stall", {31'd0, Stall}, 0);
        check("rst_idle",  {31'd0, Idle},  1);
        check("rst_err",   {31'd0, Err},   0);

        // Load-use on x5: one stall cycle.
        issue(5, 1); tick(); clear_in();
        ID_UseRs1 = 1; ID_Rs1 = 5; #1;
        check("t1_stall_on", {31'd0, Stall}, 1);
        tick(); #1;
        check("t1_stall_off", {31'd0, Stall}, 0);
        clear_in(); retire(5); tick(); clear_in(); #1;
        check("t1_idle", {31'd0, Idle}, 1);

        // ALU writer x6 fully bypassed.
        issue(6, 0); tick(); clear_in();
        ID_UseRs2 = 1; ID_Rs2 = 6; #1;
        check("t2_no_stall", {31'd0, Stall}, 0);
        check("t2_busy", {31'd0, Idle}, 0);
        tick(); clear_in(); retire(6); tick(); clear_in(); #1;
        check("t2_idle", {31'd0, Idle}, 1);

        // Two writers to x7.
        issue(7, 0); tick(); issue(7, 0); tick(); clear_in();
        retire(7); tick(); clear_in(); #1;
        check("t3_one_left", {31'd0, Idle}, 0);
        retire(7); tick(); clear_in(); #1;
        check("t3_idle", {31'd0, Idle}, 1);

        // Load x8 squashed by a flush.
        issue(8, 1); tick(); clear_in();
        Flush = 1; Flush_RegWrite = 1; Flush_Rd = 8; tick(); clear_in();
        ID_UseRs1 = 1; ID_Rs1 = 8; #1;
        check("t4_no_stall", {31'd0, Stall}, 0);
        check("t4_idle", {31'd0, Idle}, 1);
        tick(); clear_in();

        // Same-cycle issue and retire of x9.
        issue(9, 0); tick(); clear_in();
        issue(9, 0); retire(9); tick(); clear_in(); #1;
        check("t5_still_one", {31'd0, Idle}, 0);
        retire(9); tick(); clear_in(); #1;
        check("t5_idle", {31'd0, Idle}, 1);

        // Underflow is sticky, x0 is ignored, reset clears.
        retire(3); tick(); clear_in(); #1;
        check("t6_err", {31'd0, Err}, 1);
        tick(); #1;
        check("t6_err_sticky", {31'd0, Err}, 1);
        issue(0, 1); tick(); clear_in(); ID_UseRs1 = 1; ID_Rs1 = 0; #1;
        check("t6_x0_idle", {31'd0, Idle}, 1);
        check("t6_x0_stall", {31'd0, Stall}, 0);
        clear_in(); rst = 1; tick(); clear_in(); #1;
        check("t6_rst_err", {31'd0, Err}, 0);
        check("t6_rst_idle", {31'd0, Idle}, 1);

        // Randomized traffic on a small register window to force collisions.
        for (int i = 0; i < 1500; i++) begin
            int r;
            clear_in();
            rst = ($urandom_range(0, 199) == 0);
            ID_UseRs1 = $urandom_range(0, 1); ID_Rs1 = 5'($urandom_range(0, 7));
            ID_UseRs2 = $urandom_range(0, 1); ID_Rs2 = 5'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 1) begin
                ID_Issue = 1; ID_RegWrite = ($urandom_range(0, 7) != 0);
                ID_Rd = 5'($urandom_range(0, 7)); ID_MemRead = ($urandom_range(0, 2) == 0);
            end
            r = $urandom_range(1, 7);
            if ($urandom_range(0, 2) == 0 && (m_out[r] > 0 || $urandom_range(0, 19) == 0))
                retire(5'(r));
            r = $urandom_range(1, 7);
            if ($urandom_range(0, 6) == 0 && (m_out[r] > 0 || $urandom_range(0, 19) == 0)) begin
                Flush = 1; Flush_RegWrite = 1; Flush_Rd = 5'(r);
            end
            tick();
        end
        clear_in();
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
